// File: rtl/dma_channel_scheduler_if.sv
// Request/engine bundle shared by the register file, the channel scheduler
// and the DMA control FSM. The scheduler uses the slave modport.
interface dma_channel_scheduler_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]    ch_start;
  logic [16*NUM_CH-1:0] ch_length;
  logic [2*NUM_CH-1:0]  ch_width;
  logic [NUM_CH-1:0]    ch_burst_en;
  logic [NUM_CH-1:0]    ch_pending;
  logic [NUM_CH-1:0]    ch_active;
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH-1:0]    ch_error;
  logic                 eng_start;
  logic [15:0]          eng_total_length;
  logic [1:0]           eng_transfer_width;
  logic                 eng_burst_en;
  logic [CH_W-1:0]      eng_sel;
  logic                 eng_abort;
  logic                 eng_busy;
  logic                 eng_done;
  logic                 eng_error;
  logic                 sched_busy;

  modport master (
    output ch_start, ch_length, ch_width, ch_burst_en, eng_busy, eng_done, eng_error,
    input  ch_pending, ch_active, ch_done, ch_error, eng_start, eng_total_length,
           eng_transfer_width, eng_burst_en, eng_sel, eng_abort, sched_busy
  );

  modport slave (
    input  ch_start, ch_length, ch_width, ch_burst_en, eng_busy, eng_done, eng_error,
    output ch_pending, ch_active, ch_done, ch_error, eng_start, eng_total_length,
           eng_transfer_width, eng_burst_en, eng_sel, eng_abort, sched_busy
  );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Round-robin front end sharing one DMA control engine among NUM_CH channels:
// one-deep request queue per channel, launch, watchdog and per-channel retire pulses.
module dma_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 4096
) (
  input logic                   clk,
  input logic                   rst_n,
  dma_channel_scheduler_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_RETIRE = 2'd3;
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);
  localparam logic [NUM_CH-1:0] CH_ONE = {{(NUM_CH-1){1'b0}}, 1'b1};
  localparam logic [NUM_CH-1:0] CH_NONE = {NUM_CH{1'b0}};

  logic [1:0]        state_r, state_nxt_s;
  logic [NUM_CH-1:0] pending_r, active_r, done_r, error_r;
  logic [NUM_CH-1:0] req_set_s, zero_err_s, grant_clr_s;
  logic [CH_W-1:0]   sel_r, last_grant_r, win_idx_s, cand_s;
  logic              win_found_s, grant_go_s, run_end_s, run_err_s, timeout_s;
  logic [15:0]       wd_r, len_r;
  logic [1:0]        width_r;
  logic              burst_r;
  logic              eng_busy_unused_s;

  assign eng_busy_unused_s = bus.eng_busy;

  // Split incoming starts into queued requests and zero-length rejections.
  always_comb begin
    req_set_s  = CH_NONE;
    zero_err_s = CH_NONE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_length[16*i +: 16] == 16'd0) begin
        zero_err_s[i] = bus.ch_start[i];
      end else begin
        req_set_s[i] = bus.ch_start[i];
      end
    end
  end

  // Round-robin search over pending channels, starting after the last grant.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {CH_W{1'b0}};
    cand_s      = {CH_W{1'b0}};
    for (int k = 1; k <= NUM_CH; k++) begin
      cand_s = CH_W'((int'(last_grant_r) + k) % NUM_CH);
      if (!win_found_s && pending_r[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign timeout_s   = (wd_r >= WD_LIMIT);
  assign grant_go_s  = (state_r == ST_IDLE) && win_found_s;
  assign grant_clr_s = grant_go_s ? (CH_ONE << win_idx_s) : CH_NONE;

  // Next-state logic; in RUN an engine error outranks done, and done outranks the watchdog.
  always_comb begin
    state_nxt_s = state_r;
    run_end_s   = 1'b0;
    run_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (bus.eng_error) begin
          run_end_s = 1'b1;
          run_err_s = 1'b1;
        end else if (bus.eng_done) begin
          run_end_s = 1'b1;
        end else if (timeout_s) begin
          run_end_s = 1'b1;
          run_err_s = 1'b1;
        end else begin
          run_end_s = 1'b0;
        end
        state_nxt_s = run_end_s ? ST_RETIRE : ST_RUN;
      end
      ST_RETIRE: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Scheduler state, request queue, grant latches and retire pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pending_r    <= CH_NONE;
      active_r     <= CH_NONE;
      done_r       <= CH_NONE;
      error_r      <= CH_NONE;
      sel_r        <= {CH_W{1'b0}};
      last_grant_r <= CH_W'(NUM_CH - 1);
      len_r        <= 16'd0;
      width_r      <= 2'd0;
      burst_r      <= 1'b0;
      wd_r         <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= (pending_r & ~grant_clr_s) | req_set_s;
      done_r    <= (run_end_s && !run_err_s) ? (CH_ONE << sel_r) : CH_NONE;
      error_r   <= zero_err_s | ((run_end_s && run_err_s) ? (CH_ONE << sel_r) : CH_NONE);
      if (grant_go_s) begin
        sel_r    <= win_idx_s;
        len_r    <= bus.ch_length[16*win_idx_s +: 16];
        width_r  <= bus.ch_width[2*win_idx_s +: 2];
        burst_r  <= bus.ch_burst_en[win_idx_s];
        active_r <= CH_ONE << win_idx_s;
      end else if (state_r == ST_RETIRE) begin
        active_r     <= CH_NONE;
        last_grant_r <= sel_r;
      end else begin
        active_r <= active_r;
      end
      if (state_r == ST_GRANT) begin
        wd_r <= 16'd0;
      end else if ((state_r == ST_RUN) && (wd_r != 16'hFFFF)) begin
        wd_r <= wd_r + 16'd1;
      end else begin
        wd_r <= wd_r;
      end
    end
  end

  assign bus.ch_pending         = pending_r;
  assign bus.ch_active          = active_r;
  assign bus.ch_done            = done_r;
  assign bus.ch_error           = error_r;
  assign bus.eng_start          = (state_r == ST_GRANT);
  assign bus.eng_total_length   = len_r;
  assign bus.eng_transfer_width = width_r;
  assign bus.eng_burst_en       = burst_r;
  assign bus.eng_sel            = sel_r;
  assign bus.sched_busy         = (state_r != ST_IDLE);
  // Abort is only raised when neither engine pulse arrives in the expiring cycle.
  assign bus.eng_abort = (state_r == ST_RUN) && timeout_s && !bus.eng_done && !bus.eng_error;
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Bench for dma_channel_scheduler: directed vector table, hand-written corner
// sequences and random traffic, all checked against a transaction-level model.
module tb_dma_channel_scheduler;
  localparam int NC = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_channel_scheduler_if #(.NUM_CH(NC)) bus ();
  dma_channel_scheduler #(.NUM_CH(NC), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int resp_lat = 0;
  int resp_cnt = 0;
  int grants[$];

  // Model: channel owning the engine, its age (0 = launch cycle, k = k-th run cycle).
  bit          m_pend[NC];
  int          m_last, m_own, m_age;
  bit          m_ret, m_ok;
  logic [3:0]  m_zerr;
  logic [15:0] m_len;
  logic [1:0]  m_wid;
  logic        m_bst;

  typedef struct {
    logic [3:0]  start;
    logic [15:0] len;
    logic        done;
    logic        err;
    logic [3:0]  x_pend;
    logic        x_start;
    logic [1:0]  x_sel;
    logic [3:0]  x_done;
    logic [3:0]  x_err;
    logic        x_busy;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0000;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_pend[i] = 1'b0;
    m_last = NC - 1;
    m_own  = -1;
    m_age  = 0;
    m_ret  = 1'b0;
    m_ok   = 1'b0;
    m_zerr = 4'b0000;
  endtask

  task automatic check_model();
    logic [3:0] pv;
    bit run_now;
    for (int i = 0; i < NC; i++) pv[i] = m_pend[i];
    run_now = (m_own >= 0) && !m_ret && (m_age >= 1);
    chk("pending", bus.ch_pending, pv);
    chk("active", bus.ch_active, oh(m_own));
    chk("sched_busy", bus.sched_busy, m_own >= 0);
    chk("eng_start", bus.eng_start, (m_own >= 0) && (m_age == 0) && !m_ret);
    chk("ch_done", bus.ch_done, (m_ret && m_ok) ? oh(m_own) : 4'b0000);
    chk("ch_error", bus.ch_error, m_zerr | ((m_ret && !m_ok) ? oh(m_own) : 4'b0000));
    chk("eng_abort", bus.eng_abort, run_now && (m_age == TO) && !bus.eng_done && !bus.eng_error);
    if (m_own >= 0) begin
      chk("eng_sel", bus.eng_sel, m_own);
      chk("eng_len", bus.eng_total_length, m_len);
      chk("eng_width", bus.eng_transfer_width, m_wid);
      chk("eng_burst", bus.eng_burst_en, m_bst);
    end
  endtask

  task automatic model_advance();
    logic [3:0] zero, setv;
    int w, c;
    zero = 4'b0000;
    setv = 4'b0000;
    w = -1;
    for (int i = 0; i < NC; i++) begin
      if (bus.ch_start[i]) begin
        if (bus.ch_length[16*i +: 16] == 16'd0) zero[i] = 1'b1;
        else setv[i] = 1'b1;
      end
    end
    if (m_own < 0) begin
      for (int k = 1; k <= NC; k++) begin
        c = (m_last + k) % NC;
        if (w < 0 && m_pend[c]) w = c;
      end
      if (w >= 0) begin
        m_own = w; m_age = 0; m_ret = 1'b0; m_pend[w] = 1'b0;
        m_len = bus.ch_length[16*w +: 16];
        m_wid = bus.ch_width[2*w +: 2];
        m_bst = bus.ch_burst_en[w];
      end
    end else if (m_ret) begin
      m_last = m_own; m_own = -1; m_ret = 1'b0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (bus.eng_error) begin
      m_ret = 1'b1; m_ok = 1'b0;
    end else if (bus.eng_done) begin
      m_ret = 1'b1; m_ok = 1'b1;
    end else if (m_age == TO) begin
      m_ret = 1'b1; m_ok = 1'b0;
    end else begin
      m_age++;
    end
    for (int i = 0; i < NC; i++) if (setv[i]) m_pend[i] = 1'b1;
    m_zerr = zero;
  endtask

  task automatic drive_chk(input logic [3:0] st, input logic d, input logic e);
    bus.ch_start  = st;
    bus.eng_done  = d;
    bus.eng_error = e;
    #3;
    check_model();
  endtask

  task automatic finish_cyc();
    if (bus.eng_start) begin
      grants.push_back(int'(bus.eng_sel));
      resp_cnt = resp_lat;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
    end
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic auto_cyc(input logic [3:0] st);
    drive_chk(st, resp_cnt == 1, 1'b0);
    finish_cyc();
  endtask

  initial begin
    int ws, wa, we, re_flag, seen_done, seen_abort;
    logic [3:0] st;
    int exp_fair[5] = '{0, 1, 2, 3, 0};

    tbl[0]  = '{4'b0100, 16'd64, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0000, 16'd64, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0000, 16'd64, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b1};
    tbl[3]  = '{4'b0000, 16'd64, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1};
    tbl[4]  = '{4'b0000, 16'd64, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1};
    tbl[5]  = '{4'b0000, 16'd64, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0100, 4'b0000, 1'b1};
    tbl[6]  = '{4'b0010, 16'd0,  1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{4'b0000, 16'd64, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0010, 1'b0};
    tbl[8]  = '{4'b0001, 16'd64, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0000, 16'd64, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{4'b0000, 16'd64, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b1};
    tbl[11] = '{4'b0000, 16'd64, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1};
    tbl[12] = '{4'b0000, 16'd64, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1};
    tbl[13] = '{4'b0000, 16'd64, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    tbl[14] = '{4'b0000, 16'd64, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};

    bus.ch_start = 4'b0000; bus.ch_length = 64'd0; bus.ch_width = 8'd0;
    bus.ch_burst_en = 4'b0000; bus.eng_busy = 1'b0; bus.eng_done = 1'b0; bus.eng_error = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    chk("reset_len", bus.eng_total_length, 16'd0);
    chk("reset_sel", bus.eng_sel, 2'd0);
    rst_n = 1'b1;

    // Directed vector table: single request, zero length, error beats done, stray done.
    for (int r = 0; r < 15; r++) begin
      bus.ch_length = {4{tbl[r].len}};
      drive_chk(tbl[r].start, tbl[r].done, tbl[r].err);
      chk("tbl_pend", bus.ch_pending, tbl[r].x_pend);
      chk("tbl_start", bus.eng_start, tbl[r].x_start);
      if (tbl[r].x_start) begin
        chk("tbl_sel", bus.eng_sel, tbl[r].x_sel);
        chk("tbl_len", bus.eng_total_length, tbl[r].len);
      end
      chk("tbl_done", bus.ch_done, tbl[r].x_done);
      chk("tbl_err", bus.ch_error, tbl[r].x_err);
      chk("tbl_busy", bus.sched_busy, tbl[r].x_busy);
      finish_cyc();
    end

    // Reset mid-RUN: outputs drop asynchronously, lost transfer reports nothing.
    bus.ch_length = {16'd400, 16'd300, 16'd200, 16'd100};
    bus.ch_width = 8'b11100100;
    bus.ch_burst_en = 4'b1010;
    resp_lat = 0;
    auto_cyc(4'b1000);
    repeat (4) auto_cyc(4'b0000);
    rst_n = 1'b0;
    #2;
    chk("rst_pending", bus.ch_pending, 4'b0000);
    chk("rst_active", bus.ch_active, 4'b0000);
    chk("rst_done", bus.ch_done, 4'b0000);
    chk("rst_error", bus.ch_error, 4'b0000);
    chk("rst_start", bus.eng_start, 1'b0);
    chk("rst_abort", bus.eng_abort, 1'b0);
    chk("rst_busy", bus.sched_busy, 1'b0);
    chk("rst_len", bus.eng_total_length, 16'd0);
    chk("rst_width", bus.eng_transfer_width, 2'd0);
    chk("rst_burst", bus.eng_burst_en, 1'b0);
    chk("rst_sel", bus.eng_sel, 2'd0);
    model_reset();
    grants.delete();
    resp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fairness from reset, ch0 re-requests after its retire.
    resp_lat = 10;
    re_flag = 0;
    auto_cyc(4'b1111);
    for (int i = 0; i < 70; i++) begin
      st = (re_flag == 1) ? 4'b0001 : 4'b0000;
      if (re_flag == 1) re_flag = 2;
      drive_chk(st, resp_cnt == 1, 1'b0);
      if (bus.ch_done[0] && re_flag == 0) re_flag = 1;
      finish_cyc();
    end
    chk("fair_count", grants.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("fair_order", (i < grants.size()) ? grants[i] : 99, exp_fair[i]);

    // Watchdog on ch1 and ch3 with an engine that never finishes.
    grants.delete();
    resp_lat = 0;
    ws = -1; wa = -1; we = -1;
    auto_cyc(4'b1010);
    for (int i = 0; i < 45; i++) begin
      drive_chk(4'b0000, 1'b0, 1'b0);
      if (bus.eng_start && ws < 0) ws = cyc;
      if (bus.eng_abort && wa < 0) wa = cyc;
      if (bus.ch_error[1] && we < 0) we = cyc;
      finish_cyc();
    end
    chk("wd_abort_delay", wa - ws, 16);
    chk("wd_err_after_abort", we - wa, 1);
    chk("wd_first", (grants.size() > 0) ? grants[0] : 99, 1);
    chk("wd_next", (grants.size() > 1) ? grants[1] : 99, 3);

    // Done in the very cycle the watchdog expires: done wins, no abort.
    resp_lat = TO;
    seen_done = 0; seen_abort = 0;
    auto_cyc(4'b0001);
    for (int i = 0; i < 24; i++) begin
      drive_chk(4'b0000, resp_cnt == 1, 1'b0);
      if (bus.ch_done[0]) seen_done++;
      if (bus.eng_abort) seen_abort++;
      finish_cyc();
    end
    chk("edge_done", seen_done, 1);
    chk("edge_abort", seen_abort, 0);

    // Requeue on the active channel plus a duplicate start: exactly one extra run.
    grants.delete();
    resp_lat = 6;
    for (int i = 0; i < 40; i++)
      auto_cyc((i == 0 || i == 4 || i == 5) ? 4'b0100 : 4'b0000);
    chk("requeue_count", grants.size(), 2);
    for (int i = 0; i < 2; i++)
      chk("requeue_sel", (i < grants.size()) ? grants[i] : 99, 2);

    // Random traffic against the model.
    resp_lat = 0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NC; c++) begin
        bus.ch_length[16*c +: 16] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        bus.ch_width[2*c +: 2] = 2'($urandom_range(0, 3));
        bus.ch_burst_en[c] = 1'($urandom_range(0, 1));
        st[c] = ($urandom_range(0, 5) == 0);
      end
      drive_chk(st, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
      finish_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dma_channel_scheduler.md
# dma_channel_scheduler

Multi-channel front end that shares the single AXI DMA control engine among NUM_CH software channels. Each channel posts a transfer request with its own length, width and burst mode. The scheduler queues one request per channel and grants the engine round-robin. It launches the engine, watches for completion, error or timeout, and returns per-channel done/error pulses. It sits between the register file and the DMA control FSM; eng_sel steers the per-channel address registers into the datapath.

## Interface
- NUM_CH, 4: number of channels (2..8); CH_W = $clog2(NUM_CH)
- TIMEOUT, 4096: maximum RUN cycles before watchdog abort (≥16)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ch_start  in  NUM_CH  per-channel request pulse, sampled every cycle
- ch_length  in  16*NUM_CH  transfer length in beats, channel i at [16i+15:16i]
- ch_width  in  2*NUM_CH  transfer width code per channel
- ch_burst_en  in  NUM_CH  burst enable per channel
- ch_pending  out  NUM_CH  request queued, not yet granted
- ch_active  out  NUM_CH  one-hot, channel currently owns engine
- ch_done  out  NUM_CH  one-cycle completion pulse
- ch_error  out  NUM_CH  one-cycle error pulse: engine error, timeout or zero length
- eng_start  out  1  one-cycle launch pulse to engine
- eng_total_length  out  16  latched length of granted channel
- eng_transfer_width  out  2  latched width of granted channel
- eng_burst_en  out  1  latched burst enable of granted channel
- eng_sel  out  CH_W  granted channel index, used to mux address registers
- eng_abort  out  1  one-cycle watchdog pulse; drives engine soft reset
- eng_busy  in  1  engine busy
- eng_done  in  1  engine completion pulse
- eng_error  in  1  engine error pulse
- sched_busy  out  1  high in every state except IDLE

## Operation
- Request capture: ch_start[i] with ch_length[i]≠0 sets pending[i]. The channel's length, width and burst fields are sampled at grant time, not at request time. A repeat ch_start on an already pending channel is absorbed, so the queue is one deep. ch_start on the active channel sets pending, and that channel re-runs after its turn.
- ch_start[i] with ch_length[i]==0: pending is not set; ch_error[i] pulses on the next cycle.
- Arbitration: round-robin search starting at last_grant+1 and wrapping modulo NUM_CH. last_grant resets to NUM_CH-1, so channel 0 wins first.
- FSM states: IDLE, GRANT, RUN, RETIRE.
- IDLE → GRANT when any pending bit is set. On that edge, register the winner index, latch its config into eng_* outputs and clear its pending bit.
- GRANT: eng_start=1 for exactly one cycle; always → RUN.
- RUN: wait for the engine.
  - eng_error → RETIRE with status error.
  - else eng_done → RETIRE with status ok.
  - else watchdog reaches TIMEOUT → eng_abort=1 this cycle, → RETIRE with status error.
- RETIRE: pulse ch_done[sel] (ok) or ch_error[sel] (error). Set last_grant=sel; → IDLE.
- eng_done/eng_error outside RUN are ignored.
- Watchdog: 16-bit counter, cleared in GRANT, incremented each RUN cycle, saturating.
- eng_sel, eng_total_length, eng_transfer_width and eng_burst_en stay stable from GRANT through RETIRE.
- ch_active[sel]=1 in GRANT, RUN and RETIRE.

## Timing
- Reset values: all outputs 0. pending=0, last_grant=NUM_CH-1, state IDLE, watchdog 0.
- Reset mid-transfer clears all state immediately. No done or error pulse is emitted for the lost transfer.
- Latency: ch_start at cycle N → ch_pending at N+1 → GRANT (eng_start) at N+2, provided the scheduler is idle.
- Engine pulse at cycle M → RETIRE at M+1, where ch_done/ch_error is asserted.
- Back-to-back: RETIRE at M+1 → IDLE at M+2 → next eng_start at M+3.
- Simultaneous: ch_start[i] in the same cycle that pending[i] is cleared by a grant leaves pending[i]=1, so the set wins.
- Simultaneous eng_done and eng_error: error wins.
- Simultaneous eng_done and timeout in the same RUN cycle: done wins, and eng_abort is not asserted.

## Test plan
- Single request: ch_start[2], ch_length=64. Expect eng_start at +2 with eng_sel=2 and eng_total_length=64. eng_done at cycle M → ch_done[2] at M+1, sched_busy low at M+2.
- Fairness: ch_start[0..3] together, each completing in 10 cycles. Grants must be 0,1,2,3. A re-request on ch0 after its retire is granted after ch3.
- Error paths:
  - eng_error during RUN → ch_error only, no ch_done.
  - ch_length=0 → ch_error on the next cycle, no eng_start.
- Watchdog: TIMEOUT=16 with eng_done never asserted. Expect eng_abort exactly 16 RUN cycles after GRANT, then ch_error[sel], then the next pending channel is granted.
- Requeue: ch_start on the active channel during RUN → that channel is granted again after its retire. A duplicate start while pending → only one extra transfer.
- Reset: assert rst_n low mid-RUN. All outputs must be 0 asynchronously, and after release channel 0 wins first.
